// File: rtl/calc_pkg.sv
// Shared types and sizing for the calculator entry controller and its divider.
package calc_pkg;

    localparam int CALC_OPERAND_W = 14;
    localparam int CALC_MAX_VALUE = 9999;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_t;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        COMPUTE = 3'd2,
        DIVIDE  = 3'd3,
        RESULT  = 3'd4,
        ERROR   = 3'd5
    } calc_state_t;

endpackage

// File: rtl/calc_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done is the last iteration (OPERAND_W cycles after start).
// No backpressure: start is accepted at any time, abort clears it immediately.
module calc_divider
    import calc_pkg::*;
#(
    parameter int OPERAND_W = CALC_OPERAND_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [OPERAND_W-1:0] dividend,
    input  logic [OPERAND_W-1:0] divisor,
    output logic [OPERAND_W-1:0] quotient,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = (OPERAND_W > 1) ? $clog2(OPERAND_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(OPERAND_W - 1);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [OPERAND_W-1:0] rem_q;
    logic [OPERAND_W-1:0] quo_q;
    logic [OPERAND_W-1:0] dvs_q;

    logic [OPERAND_W:0]   rem_sh;
    logic [OPERAND_W-1:0] rem_sub;
    logic                 ge;
    logic [OPERAND_W-1:0] rem_n;
    logic [OPERAND_W-1:0] quo_n;

    // The dividend shifts out of quo_q as quotient bits shift in.
    always_comb begin
        rem_sh  = {rem_q, quo_q[OPERAND_W-1]};
        ge      = (rem_sh >= {1'b0, dvs_q});
        rem_sub = rem_sh[OPERAND_W-1:0] - dvs_q;
        rem_n   = ge ? rem_sub : rem_sh[OPERAND_W-1:0];
        quo_n   = {quo_q[OPERAND_W-2:0], ge};
    end

    // Quotient is presented combinationally so the final bit lands in the done cycle.
    assign done     = busy_q && (cnt_q == LAST);
    assign quotient = quo_n;
    assign busy     = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator operand-entry sequencer: add/sub/mul resolve 2 cycles after the ENTER_B edge, div OPERAND_W+2.
// No backpressure: btn_next is ignored while busy, a btn_clear edge aborts from any state.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int OPERAND_W = CALC_OPERAND_W,
    parameter int MAX_VALUE = CALC_MAX_VALUE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_next,
    input  logic                 btn_clear,
    input  logic [1:0]           op_sel,
    input  logic [OPERAND_W-1:0] number_1,
    input  logic [OPERAND_W-1:0] number_2,
    output logic                 write_number_select,
    output logic                 number_clear,
    output logic                 busy,
    output logic [OPERAND_W-1:0] display_value,
    output logic                 display_negative,
    output logic                 display_error
);

    localparam logic [OPERAND_W-1:0]   MAX_OP   = OPERAND_W'(MAX_VALUE);
    localparam logic [OPERAND_W:0]     MAX_SUM  = (OPERAND_W + 1)'(MAX_VALUE);
    localparam logic [2*OPERAND_W-1:0] MAX_PROD = (2 * OPERAND_W)'(MAX_VALUE);

    calc_state_t          state_q, state_d;
    logic                 btn_next_q, btn_clear_q;
    logic                 next_edge, clear_edge;
    logic [OPERAND_W-1:0] a_q, b_q;
    calc_op_t             op_q;
    logic [OPERAND_W-1:0] result_q, result_d;
    logic                 neg_q, neg_d;
    logic                 clr_d;
    logic                 latch_ops;

    logic [OPERAND_W:0]     sum;
    logic [2*OPERAND_W-1:0] prod;
    logic                   a_ge_b;
    logic                   calc_err;

    logic                 div_start;
    logic [OPERAND_W-1:0] div_quotient;
    logic                 div_done;
    logic                 div_busy;

    assign next_edge  = btn_next & ~btn_next_q;
    assign clear_edge = btn_clear & ~btn_clear_q;

    // Overflow checks run on full-width intermediates before truncation.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        prod     = {{OPERAND_W{1'b0}}, a_q} * {{OPERAND_W{1'b0}}, b_q};
        a_ge_b   = (a_q >= b_q);
        calc_err = (a_q > MAX_OP) || (b_q > MAX_OP)
                || ((op_q == OP_DIV) && (b_q == '0))
                || ((op_q == OP_ADD) && (sum > MAX_SUM))
                || ((op_q == OP_MUL) && (prod > MAX_PROD));
    end

    assign div_start = (state_q == COMPUTE) && (op_q == OP_DIV) && !calc_err;

    calc_divider #(
        .OPERAND_W (OPERAND_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (clear_edge),
        .dividend (a_q),
        .divisor  (b_q),
        .quotient (div_quotient),
        .done     (div_done),
        .busy     (div_busy)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        neg_d     = neg_q;
        clr_d     = 1'b0;
        latch_ops = 1'b0;
        if (clear_edge) begin
            state_d  = ENTER_A;
            clr_d    = 1'b1;
            result_d = '0;
            neg_d    = 1'b0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (next_edge) state_d = ENTER_B;
                end
                ENTER_B: begin
                    if (next_edge) begin
                        latch_ops = 1'b1;
                        state_d   = COMPUTE;
                    end
                end
                COMPUTE: begin
                    neg_d = 1'b0;
                    if (calc_err) begin
                        result_d = '0;
                        state_d  = ERROR;
                    end else begin
                        case (op_q)
                            OP_ADD: begin
                                result_d = sum[OPERAND_W-1:0];
                                state_d  = RESULT;
                            end
                            OP_SUB: begin
                                result_d = a_ge_b ? (a_q - b_q) : (b_q - a_q);
                                neg_d    = ~a_ge_b;
                                state_d  = RESULT;
                            end
                            OP_MUL: begin
                                result_d = prod[OPERAND_W-1:0];
                                state_d  = RESULT;
                            end
                            default: state_d = DIVIDE;
                        endcase
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        result_d = div_quotient;
                        neg_d    = 1'b0;
                        state_d  = RESULT;
                    end
                end
                RESULT, ERROR: begin
                    if (next_edge) begin
                        state_d = ENTER_A;
                        clr_d   = 1'b1;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ENTER_A;
            btn_next_q   <= 1'b0;
            btn_clear_q  <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            result_q     <= '0;
            neg_q        <= 1'b0;
            number_clear <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_next_q   <= btn_next;
            btn_clear_q  <= btn_clear;
            result_q     <= result_d;
            neg_q        <= neg_d;
            number_clear <= clr_d;
            if (latch_ops) begin
                a_q  <= number_1;
                b_q  <= number_2;
                op_q <= calc_op_t'(op_sel);
            end
        end
    end

    // Only the live operand views in ENTER_A/ENTER_B reach outputs from inputs.
    always_comb begin
        write_number_select = (state_q == ENTER_B);
        busy                = (state_q == COMPUTE) || div_busy;
        display_negative    = (state_q == RESULT) && neg_q;
        display_error       = (state_q == ERROR);
        case (state_q)
            ENTER_A: display_value = number_1;
            ENTER_B: display_value = number_2;
            RESULT:  display_value = result_q;
            default: display_value = '0;
        endcase
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Randomized bench for calc_entry_ctrl against an arithmetic reference model.
module tb_calc_entry_ctrl;
    import calc_pkg::*;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_next = 1'b0;
    logic         btn_clear = 1'b0;
    logic [1:0]   op_sel = 2'd0;
    logic [W-1:0] number_1 = '0;
    logic [W-1:0] number_2 = '0;
    logic         write_number_select;
    logic         number_clear;
    logic         busy;
    logic [W-1:0] display_value;
    logic         display_negative;
    logic         display_error;

    int n_tests = 0;
    int n_fail  = 0;

    calc_entry_ctrl #(.OPERAND_W(W), .MAX_VALUE(9999)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .btn_next            (btn_next),
        .btn_clear           (btn_clear),
        .op_sel              (op_sel),
        .number_1            (number_1),
        .number_2            (number_2),
        .write_number_select (write_number_select),
        .number_clear        (number_clear),
        .busy                (busy),
        .display_value       (display_value),
        .display_negative    (display_negative),
        .display_error       (display_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_next();
        tick();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
    endtask

    task automatic press_clear();
        tick();
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
    endtask

    // Reference: what the calculator should show for a given entry.
    function automatic void model(input int a, input int b, input int op,
                                  output int val, output bit neg, output bit err,
                                  output int busy_cycles);
        val = 0;
        neg = 1'b0;
        err = (a > 9999) || (b > 9999);
        if (!err) begin
            case (op)
                0: begin val = a + b; err = (val > 9999); end
                1: begin neg = (a < b); val = neg ? b - a : a - b; end
                2: begin val = a * b; err = (val > 9999); end
                default: begin err = (b == 0); if (!err) val = a / b; end
            endcase
        end
        if (err) begin
            val = 0;
            neg = 1'b0;
        end
        busy_cycles = (!err && op == 3) ? 15 : 1;
    endfunction

    task automatic run_calc(input string tag, input int a, input int b, input int op);
        int  exp_val, exp_busy, cnt;
        bit  exp_neg, exp_err;
        model(a, b, op, exp_val, exp_neg, exp_err, exp_busy);
        number_1 = W'(a);
        #1;
        chk({tag, "_a_disp"}, display_value, a);
        chk({tag, "_a_wns"}, write_number_select, 0);
        press_next();
        number_2 = W'(b);
        op_sel   = 2'(op);
        #1;
        chk({tag, "_b_wns"}, write_number_select, 1);
        chk({tag, "_b_disp"}, display_value, b);
        press_next();
        // Operands must already be captured; scramble the inputs.
        number_1 = W'($urandom_range(0, 16383));
        number_2 = W'($urandom_range(0, 16383));
        op_sel   = 2'($urandom_range(0, 3));
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk({tag, "_busy_cyc"}, cnt, exp_busy);
        chk({tag, "_err"}, display_error, exp_err);
        chk({tag, "_val"}, display_value, exp_val);
        chk({tag, "_neg"}, display_negative, exp_neg);
        chk({tag, "_res_wns"}, write_number_select, 0);
        press_next();
        chk({tag, "_nclr_on"}, number_clear, 1);
        chk({tag, "_back_a"}, display_error | busy | write_number_select | display_negative, 0);
        tick();
        chk({tag, "_nclr_off"}, number_clear, 0);
    endtask

    function automatic int pick_operand();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0: return $urandom_range(0, 150);
            1: return $urandom_range(0, 9999);
            2: return $urandom_range(0, 16383);
            default: begin
                sel = $urandom_range(0, 3);
                return (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 9999 : 10000;
            end
        endcase
    endfunction

    initial begin
        int viol;
        #1;
        chk("rst_wns", write_number_select, 0);
        chk("rst_nclr", number_clear, 0);
        chk("rst_busy", busy, 0);
        chk("rst_disp", display_value, 0);
        chk("rst_neg", display_negative, 0);
        chk("rst_err", display_error, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_calc("add25_17", 25, 17, 0);
        run_calc("sub17_25", 17, 25, 1);
        run_calc("mul100", 100, 100, 2);
        run_calc("mul99_101", 99, 101, 2);
        run_calc("div9999_7", 9999, 7, 3);
        run_calc("div_by0", 5, 0, 3);
        run_calc("a_12000", 12000, 3, 0);
        run_calc("add_9999", 5000, 4999, 0);
        run_calc("add_10000", 5000, 5000, 0);
        run_calc("sub_zero", 0, 0, 1);
        run_calc("div_by1", 9999, 1, 3);
        run_calc("b_over", 3, 16383, 1);

        for (int i = 0; i < 30; i++) begin
            run_calc($sformatf("rnd%0d", i), pick_operand(), pick_operand(),
                     int'($urandom_range(0, 3)));
        end

        // Clear during the fifth DIVIDE cycle.
        number_1 = W'(500);
        press_next();
        number_2 = W'(7);
        op_sel   = 2'd3;
        press_next();
        repeat (5) tick();
        chk("abort_in_div", busy, 1);
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        chk("abort_nclr", number_clear, 1);
        chk("abort_busy", busy, 0);
        chk("abort_disp", display_value, 500);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || display_negative || display_error || write_number_select ||
                number_clear || display_value != 500) viol++;
        end
        chk("abort_quiet", viol, 0);

        // Simultaneous next and clear edges in ENTER_B.
        number_1 = W'(3);
        press_next();
        number_2 = W'(4);
        op_sel   = 2'd0;
        tick();
        btn_next  = 1'b1;
        btn_clear = 1'b1;
        tick();
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        chk("both_wns", write_number_select, 0);
        chk("both_busy", busy, 0);
        chk("both_nclr", number_clear, 1);
        tick();
        chk("both_busy2", busy, 0);

        // Held btn_next acts once.
        tick();
        btn_next = 1'b1;
        repeat (50) tick();
        chk("held_wns", write_number_select, 1);
        chk("held_busy", busy, 0);
        btn_next = 1'b0;
        press_clear();
        chk("held_clr_wns", write_number_select, 0);

        // Clear out of ERROR.
        number_1 = W'(12000);
        press_next();
        press_next();
        tick();
        chk("err_state", display_error, 1);
        press_clear();
        chk("err_clr", display_error, 0);
        chk("err_clr_nclr", number_clear, 1);
        tick();

        // Asynchronous reset mid-divide.
        number_1 = W'(9999);
        press_next();
        number_2 = W'(3);
        op_sel   = 2'd3;
        press_next();
        repeat (3) tick();
        number_1 = '0;
        number_2 = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_wns", write_number_select, 0);
        chk("arst_nclr", number_clear, 0);
        chk("arst_disp", display_value, 0);
        chk("arst_neg", display_negative, 0);
        chk("arst_err", display_error, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_calc("post_rst_div", 9999, 3, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Sequencing controller for the calculator's operand-entry datapath. Steers slider increments to operand A or B via `write_number_select`, samples both operands and the operator, and runs the arithmetic: add, sub and mul in one cycle, div iteratively. Holds the result and the error state for the display path, and requests operand clears from the entry datapath between calculations.

## Interface
Parameters:
- `OPERAND_W`, 14: operand, result and display width.
- `MAX_VALUE`, 9999: largest legal operand or result magnitude (4-digit display).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn_next`  in  1: synchronized, debounced level; only its rising edge acts.
- `btn_clear`  in  1: synchronized, debounced level; only its rising edge acts.
- `op_sel`  in  2: operator. 0 = ADD, 1 = SUB, 2 = MUL, 3 = DIV.
- `number_1`  in  OPERAND_W: operand A from the entry datapath.
- `number_2`  in  OPERAND_W: operand B from the entry datapath.
- `write_number_select`  out  1: 0 steers entry to A, 1 steers entry to B.
- `number_clear`  out  1: one-cycle pulse; entry datapath zeroes both operands.
- `busy`  out  1: high in COMPUTE and DIVIDE.
- `display_value`  out  OPERAND_W: value to show.
- `display_negative`  out  1: result sign.
- `display_error`  out  1: high in ERROR.

## Operation
- States: ENTER_A, ENTER_B, COMPUTE, DIVIDE, RESULT, ERROR.
- Reset values: ENTER_A, `write_number_select` = 0, `number_clear` = 0, `busy` = 0, `display_value` = 0, `display_negative` = 0, `display_error` = 0.
- Edge detect: one register per button. An edge is `btn & ~btn_q`. A held button acts once.
- `btn_clear` edge, in any state, takes priority over everything else:
  - next state is ENTER_A;
  - `number_clear` pulses;
  - an in-flight divide is aborted;
  - the result and error registers are zeroed.
- ENTER_A:
  - `display_value` = `number_1` (live).
  - `btn_next` edge: go to ENTER_B.
- ENTER_B:
  - `write_number_select` = 1 and `display_value` = `number_2` (live).
  - `btn_next` edge: latch `number_1`, `number_2` and `op_sel` into operand registers, then go to COMPUTE.
- COMPUTE (exactly 1 cycle). ERROR is taken if any of these hold:
  - either latched operand > MAX_VALUE;
  - DIV with B = 0;
  - ADD sum > MAX_VALUE;
  - MUL product > MAX_VALUE. The product is computed at 2*OPERAND_W width and compared before truncation.
- COMPUTE, no error:
  - ADD: result = A + B.
  - SUB: if A ≥ B, result = A − B with negative = 0; otherwise result = B − A with negative = 1.
  - MUL: result = A × B.
  - ADD, SUB and MUL go to RESULT.
  - DIV pulses divider start and goes to DIVIDE.
- DIVIDE:
  - Restoring divider, OPERAND_W iterations, one bit per cycle.
  - On divider done: result = quotient (floor, remainder discarded), then go to RESULT.
- RESULT: `display_value` = result, `display_negative` as computed. `btn_next` edge goes to ENTER_A with a `number_clear` pulse.
- ERROR: `display_error` = 1 and `display_value` = 0. A `btn_next` edge or a `btn_clear` edge goes to ENTER_A with a `number_clear` pulse.
- `btn_next` is ignored in COMPUTE and DIVIDE.
- `display_negative` is 0 in every state except RESULT.

## Timing
- Edge visible in cycle N (`btn` high, `btn_q` low) → state changes at clock edge N+1.
- `number_clear` is asserted for exactly the first cycle of the new ENTER_A.
- ADD, SUB, MUL: the ENTER_B `btn_next` edge at N gives COMPUTE at N+1 and RESULT at N+2.
- DIV: COMPUTE at N+1, DIVIDE at N+2 through N+1+OPERAND_W, RESULT at N+2+OPERAND_W (16 cycles after the edge for 14-bit operands).
- Operands and operator are sampled only on the ENTER_B→COMPUTE transition. Later changes to `number_1`, `number_2` or `op_sel` have no effect.
- All outputs are registered, or decoded from state and registers only, with no input-to-output combinational path. Exception: the live operand display in ENTER_A and ENTER_B.
- `rst_n` asserted mid-divide: immediate return to reset values, and the divider state is cleared.

## Structure
- Package `calc_pkg`:
  - `calc_state_t` enum (6 states);
  - `calc_op_t` enum (ADD/SUB/MUL/DIV = 0..3);
  - `CALC_OPERAND_W` = 14 and `CALC_MAX_VALUE` = 9999.
- Sub-module `calc_divider`:
  - inputs: `clk`, `rst_n`, `start`, `abort`, `dividend`, `divisor`;
  - outputs: `quotient`, `done` (1-cycle pulse), `busy`.
- The top level holds the FSM, the edge detectors, and the add/sub/mul logic with overflow checks.

## Test plan
- Reset, then A = 25, next, B = 17, ADD, next → RESULT 2 cycles after the edge, with `display_value` = 42, negative = 0, and `write_number_select` = 1 during ENTER_B only.
- A = 17, B = 25, SUB → `display_value` = 8, `display_negative` = 1. Then `btn_next` → ENTER_A with a one-cycle `number_clear` pulse.
- A = 100, B = 100, MUL → ERROR (10000 > 9999), `display_error` = 1, `display_value` = 0. A = 99, B = 101 → 9999 with no error.
- A = 9999, B = 7, DIV → `busy` held 15 cycles, RESULT 16 cycles after the edge, `display_value` = 1428. With B = 0 → ERROR one cycle after COMPUTE.
- `btn_clear` edge at the 5th DIVIDE cycle → ENTER_A next cycle, `number_clear` pulse, no later `done` effect. Simultaneous `btn_next` and `btn_clear` edges in ENTER_B → ENTER_A, not COMPUTE.
- `btn_next` held high for 50 cycles in ENTER_A → exactly one transition, to ENTER_B. `number_1` = 12000 latched → ERROR. `rst_n` low mid-DIVIDE → all outputs at reset values within the same cycle.
